glitch_pulse_monitor: RTL and testbench
=======================================

// Module: glitch_pulse_monitor
// PURPOSE
// - Measures the glitch pulse at its receiving end for loopback self-test and characterisation.
// - Once armed, it timestamps the trigger rising edge and the following pulse rising edge.
// - Reports the trigger-to-pulse delay and the pulse width in clk cycles through a valid/ready result port.
// - Connects to the trigger input and the pulse output of the glitch controller, read back externally.
// PARAMETERS
// - CNT_W        24   width of the delay and width counters; both saturate at 2**CNT_W-1
// - SYNC_STAGES  2    synchroniser depth on trigger_i and pulse_i (minimum 2)
// - GAP_CYCLES   256  burst-end idle gap in cycles; used only with GLITCH_PULSE_MON_BURST_EN
// PORTS
// - clk           in   1      system clock
// - rst_n         in   1      asynchronous reset, active-low
// - arm_i         in   1      single-cycle arm request; honoured only in IDLE
// - trigger_i     in   1      asynchronous trigger line (target side)
// - pulse_i       in   1      asynchronous glitch pulse line under test
// - busy_o        out  1      high in every state except IDLE
// - meas_valid_o  out  1      result available; held until accepted
// - meas_ready_i  in   1      result accepted when valid && ready
// - delay_o       out  CNT_W  cycles from the trigger rising edge to the first pulse rising edge
// - width_o       out  CNT_W  cycles the first pulse is high
// - pulse_cnt_o   out  8      number of pulses seen in the burst
// - timeout_o     out  1      a counter saturated during this measurement
// BEHAVIOUR
// - Reset (async): state=IDLE; all outputs 0; counters 0; synchroniser flops 0.
// - trigger_i and pulse_i pass through identical SYNC_STAGES flop chains.
// - Rising-edge detect uses one extra flop on each chain, so both paths have equal latency and the measured delay is not skewed.
// - IDLE: on arm_i -> ARMED. Counters are cleared on entry to ARMED.
// - ARMED: on trigger rise -> DELAY with the delay count = 0.
//   - If the trigger rise and the pulse rise occur in the same cycle -> WIDTH with delay = 0.
//   - A pulse rise without a trigger rise is ignored.
// - DELAY: delay += 1 each cycle.
//   - On pulse rise -> WIDTH with width = 1.
//   - At saturation -> DONE with timeout = 1.
// - WIDTH: width += 1 each cycle while the synchronised pulse is high.
//   - On the pulse falling edge -> DONE (or GAP, see CONFIGURATION).
//   - At saturation -> DONE with timeout = 1.
// - DONE: meas_valid_o = 1; delay_o, width_o, pulse_cnt_o and timeout_o are stable.
//   - valid && ready -> IDLE; meas_valid_o drops on the next cycle.
//   - Further trigger or pulse edges are ignored.
// - Output registers update only on entry to DONE, so the previous result stays visible until then.
// - pulse_cnt_o saturates at 255.
// - arm_i is ignored outside IDLE; it is not queued.
// - A trigger rise in DELAY or WIDTH is ignored; no re-arm.
// - Reset during any state aborts to IDLE immediately; a partial result is discarded.
// - Counter arithmetic is unsigned; saturating adds never wrap.
// CONFIGURATION
// - Optional feature macro: GLITCH_PULSE_MON_BURST_EN.
// - Defined: after the first pulse falls -> GAP state, which counts idle cycles.
//   - Each further pulse rise increments pulse_cnt_o and resets the gap count.
//   - GAP_CYCLES consecutive low cycles -> DONE.
//   - delay_o and width_o always describe the first pulse only.
// - Undefined: there is no GAP state and GAP_CYCLES is unused.
//   - The first pulse falling edge -> DONE directly.
//   - pulse_cnt_o = 1 on a normal completion, or 0 if the measurement timed out in DELAY.
// TESTING
// - T1 basic: arm, trigger rise, pulse rise 100 cycles later, pulse high 7 cycles
//   -> delay_o=100, width_o=7, pulse_cnt_o=1, timeout_o=0.
// - T2 same-cycle edges: trigger and pulse rise on the same clk edge, pulse high 3 cycles
//   -> delay_o=0, width_o=3.
// - T3 timeout: CNT_W=8, arm, trigger, no pulse
//   -> after 255 cycles meas_valid_o=1, timeout_o=1, delay_o=255, pulse_cnt_o=0.
// - T4 handshake: hold meas_ready_i=0 for 50 cycles after valid
//   -> outputs stable and valid held; pulse edges and arm_i ignored.
//   -> ready=1 -> IDLE, busy_o=0 the next cycle.
// - T5 unarmed and reset: trigger and pulse edges with no arm -> meas_valid_o never asserts.
//   - Arm, trigger, then rst_n=0 mid-DELAY -> all outputs 0 asynchronously.
//   - A re-armed run after reset then measures correctly.
// - T6 burst (GLITCH_PULSE_MON_BURST_EN, GAP_CYCLES=16): pulses of width 5 spaced 10 cycles apart, 4 pulses
//   -> pulse_cnt_o=4, width_o=5, valid 16 cycles after the last pulse falls.

Source files
------------

// File: rtl/glitch_pulse_monitor.sv
// Purpose: timestamps trigger->pulse delay and pulse width of a looped-back glitch pulse.
// Latency: inputs reach the FSM SYNC_STAGES+1 cycles after they change; the result is valid one cycle after the pulse falls.
// Backpressure: the result is held in DONE until meas_valid_o && meas_ready_i; nothing is measured meanwhile.
//
// Ports: clk/rst_n (async active-low); arm_i starts a measurement from IDLE;
//   trigger_i/pulse_i are asynchronous lines under test; busy_o = not IDLE;
//   meas_valid_o/meas_ready_i result handshake; delay_o, width_o (CNT_W, saturating),
//   pulse_cnt_o (8b, saturating), timeout_o (a counter saturated).
// Build option: define GLITCH_PULSE_MON_BURST_EN to count a burst of pulses,
//   ending after GAP_CYCLES consecutive low cycles.
module glitch_pulse_monitor #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter int GAP_CYCLES  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_i,
  input  logic             trigger_i,
  input  logic             pulse_i,
  output logic             busy_o,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic [CNT_W-1:0] delay_o,
  output logic [CNT_W-1:0] width_o,
  output logic [7:0]       pulse_cnt_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_WIDTH,
`ifdef GLITCH_PULSE_MON_BURST_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] delay_q, delay_n;
  logic [CNT_W-1:0] width_q, width_n;
  logic [7:0]       pcnt_q, pcnt_n;
  logic             tmo_n;

`ifdef GLITCH_PULSE_MON_BURST_EN
  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  logic [GAP_W-1:0] gap_q, gap_n;
`else
  // GAP_CYCLES only matters in burst mode.
  logic unused_gap_cfg;
  assign unused_gap_cfg = (GAP_CYCLES != 0);
`endif

  // Identical chains on both lines, plus one edge-detect flop each, so the
  // two paths have equal latency and the measured delay is unskewed.
  logic [SYNC_STAGES-1:0] trig_sync, pulse_sync;
  logic                   trig_prev, pulse_prev;
  logic                   trig_s, pulse_s, trig_rise, pulse_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_sync  <= '0;
      pulse_sync <= '0;
      trig_prev  <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      trig_sync  <= {trig_sync[SYNC_STAGES-2:0], trigger_i};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse_i};
      trig_prev  <= trig_s;
      pulse_prev <= pulse_s;
    end
  end

  assign trig_s     = trig_sync[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync[SYNC_STAGES-1];
  assign trig_rise  = trig_s & ~trig_prev;
  assign pulse_rise = pulse_s & ~pulse_prev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_n = state;
    delay_n = delay_q;
    width_n = width_q;
    pcnt_n  = pcnt_q;
    tmo_n   = 1'b0;
`ifdef GLITCH_PULSE_MON_BURST_EN
    gap_n   = gap_q;
`endif
    case (state)
      S_IDLE: begin
        if (arm_i) begin
          state_n = S_ARMED;
          delay_n = '0;
          width_n = '0;
          pcnt_n  = 8'd0;
`ifdef GLITCH_PULSE_MON_BURST_EN
          gap_n   = '0;
`endif
        end
      end
      S_ARMED: begin
        // A pulse rise without a trigger rise is ignored here.
        if (trig_rise) begin
          delay_n = '0;
          if (pulse_rise) begin
            state_n = S_WIDTH;
            width_n = CNT_ONE;
            pcnt_n  = 8'd1;
          end else begin
            state_n = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        // The pulse-rise cycle is counted too, so delay = rise-to-rise distance.
        delay_n = sat_inc(delay_q);
        if (pulse_rise) begin
          state_n = S_WIDTH;
          width_n = CNT_ONE;
          pcnt_n  = 8'd1;
        end else if (delay_n == CNT_MAX) begin
          state_n = S_DONE;
          tmo_n   = 1'b1;
        end
      end
      S_WIDTH: begin
        if (!pulse_s) begin
`ifdef GLITCH_PULSE_MON_BURST_EN
          // The falling-edge cycle is already the first low cycle of the gap.
          state_n = S_GAP;
          gap_n   = GAP_ONE;
`else
          state_n = S_DONE;
`endif
        end else begin
          width_n = sat_inc(width_q);
          if (width_n == CNT_MAX) begin
            state_n = S_DONE;
            tmo_n   = 1'b1;
          end
        end
      end
`ifdef GLITCH_PULSE_MON_BURST_EN
      S_GAP: begin
        if (pulse_s) begin
          gap_n = '0;
          if (pulse_rise && (pcnt_q != 8'hFF)) pcnt_n = pcnt_q + 8'd1;
        end else begin
          gap_n = gap_q + GAP_ONE;
          if (gap_n == GAP_LAST) state_n = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (meas_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      delay_q <= '0;
      width_q <= '0;
      pcnt_q  <= 8'd0;
`ifdef GLITCH_PULSE_MON_BURST_EN
      gap_q   <= '0;
`endif
    end else begin
      state   <= state_n;
      delay_q <= delay_n;
      width_q <= width_n;
      pcnt_q  <= pcnt_n;
`ifdef GLITCH_PULSE_MON_BURST_EN
      gap_q   <= gap_n;
`endif
    end
  end

  // Result registers load only on entry to DONE; the previous result stays
  // visible throughout the next measurement.
  logic load_result;
  assign load_result = (state_n == S_DONE) && (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_o     <= '0;
      width_o     <= '0;
      pulse_cnt_o <= 8'd0;
      timeout_o   <= 1'b0;
    end else if (load_result) begin
      delay_o     <= delay_n;
      width_o     <= width_n;
      pulse_cnt_o <= pcnt_n;
      timeout_o   <= tmo_n;
    end
  end

  assign busy_o       = (state != S_IDLE);
  assign meas_valid_o = (state == S_DONE);

endmodule

// File: tb/tb_glitch_pulse_monitor.sv
`timescale 1ns/1ps
module tb_glitch_pulse_monitor;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int GAP   = 16;
  localparam int PER   = 10;                 // burst pulse spacing, rise to rise
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0, trig = 1'b0, pulse = 1'b0, ready = 1'b0;
  logic busy, valid, tmo;
  logic [CNT_W-1:0] delay, width;
  logic [7:0] pcnt;

  glitch_pulse_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .trigger_i(trig), .pulse_i(pulse),
    .busy_o(busy), .meas_valid_o(valid), .meas_ready_i(ready),
    .delay_o(delay), .width_o(width), .pulse_cnt_o(pcnt), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected result and the cycle windows in which busy/valid hold.
  int busy_from = NEVER, valid_from = NEVER, idle_from = NEVER;
  int res_delay = 0, res_width = 0, res_cnt = 0, res_tmo = 0;
  int prv_delay = 0, prv_width = 0, prv_cnt = 0, prv_tmo = 0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pulse_at(input int t, input int w, input int np);
    for (int k = 0; k < np; k++)
      if (t >= k * PER && t < k * PER + w) return 1'b1;
    return 1'b0;
  endfunction

  // Arm at cycle a, trigger driven at c, first pulse d cycles later, np pulses of width w.
  // Every input is seen by the monitor SYNC cycles after it is driven.
  task automatic model_expect(input int a, input int c, input int d, input int w, input int np);
    int p;
    prv_delay = res_delay; prv_width = res_width; prv_cnt = res_cnt; prv_tmo = res_tmo;
    busy_from = a + 1;
    idle_from = NEVER;
    p = c + d;
    if (np == 0 || d > MAXV) begin
      res_delay = MAXV; res_width = 0; res_cnt = 0; res_tmo = 1;
      valid_from = c + SYNC + 1 + MAXV;
    end else if (w >= MAXV) begin
      res_delay = d; res_width = MAXV; res_cnt = 1; res_tmo = 1;
      valid_from = p + SYNC + MAXV;
    end else begin
      res_delay = d; res_width = w; res_tmo = 0;
`ifdef GLITCH_PULSE_MON_BURST_EN
      res_cnt = (np > 255) ? 255 : np;
      valid_from = p + PER * (np - 1) + w + SYNC + GAP;
`else
      res_cnt = 1;
      valid_from = p + w + SYNC + 1;
`endif
    end
  endtask

  // Per-cycle comparison against the model.
  bit e_busy, e_valid, e_new;
  always @(negedge clk) begin
    e_busy  = (cyc >= busy_from) && (cyc < idle_from);
    e_valid = (cyc >= valid_from) && (cyc < idle_from);
    e_new   = (cyc >= valid_from);
    chk("busy", busy, e_busy);
    chk("meas_valid", valid, e_valid);
    chk("delay", delay, e_new ? res_delay : prv_delay);
    chk("width", width, e_new ? res_width : prv_width);
    chk("pulse_cnt", pcnt, e_new ? res_cnt : prv_cnt);
    chk("timeout", tmo, e_new ? res_tmo : prv_tmo);
  end

  task automatic run_meas(input int d, input int w, input int np, input int hold, input bit noise);
    int a, c, last;
    step();
    a = cyc;
    c = a + 3;
    model_expect(a, c, d, w, np);
    arm = 1'b1;
    last = (np == 0) ? c + 4 : c + d + PER * (np - 1) + w + 2;
    while (cyc < last) begin
      step();
      if (cyc == a + 1) arm = 1'b0;
      trig  = (cyc >= c) && (cyc < last);
      pulse = pulse_at(cyc - c - d, w, np);
    end
    trig = 1'b0; pulse = 1'b0;
    while (cyc < valid_from + hold) begin
      step();
      if (noise && cyc > valid_from && cyc < valid_from + hold - 5) begin
        pulse = (cyc % 4) < 2;
        trig  = (cyc % 6) < 3;
        arm   = (cyc % 7) == 0;
      end else begin
        pulse = 1'b0; trig = 1'b0; arm = 1'b0;
      end
    end
    ready = 1'b1;
    idle_from = cyc + 1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_delay", delay, 0);
    chk("rst_pcnt", pcnt, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // T1 basic
    run_meas(100, 7, 1, 0, 0);
    chk("t1_delay", delay, 100);
    chk("t1_width", width, 7);
    chk("t1_pcnt", pcnt, 1);
    chk("t1_timeout", tmo, 0);

    // T2 same-cycle trigger and pulse
    run_meas(0, 3, 1, 2, 0);
    chk("t2_delay", delay, 0);
    chk("t2_width", width, 3);

    // T3 no pulse -> delay saturates
    run_meas(0, 0, 0, 3, 0);
    chk("t3_delay", delay, 255);
    chk("t3_timeout", tmo, 1);
    chk("t3_pcnt", pcnt, 0);
    chk("t3_width", width, 0);

    // Delay one short of saturation, single-cycle pulse
    run_meas(254, 1, 1, 0, 0);
    chk("sat_edge_delay", delay, 254);
    chk("sat_edge_width", width, 1);
    chk("sat_edge_timeout", tmo, 0);

    // T4 ready held low 50 cycles with edges and arm toggling meanwhile
    run_meas(40, 9, 1, 50, 1);
    chk("t4_delay", delay, 40);
    chk("t4_width", width, 9);
    step();
    chk("t4_idle_busy", busy, 0);

    // T5 edges without arm must not start a measurement
    for (int i = 0; i < 30; i++) begin
      step();
      trig  = (i % 8) < 4;
      pulse = (i % 5) < 2;
    end
    trig = 1'b0; pulse = 1'b0;
    repeat (6) step();
    chk("t5_unarmed_valid", valid, 0);

    // T5 reset in the middle of DELAY
    begin
      int a;
      a = cyc;
      model_expect(a, a + 3, 200, 5, 1);
      arm = 1'b1;
      step(); arm = 1'b0;
      step(); step(); trig = 1'b1;
      repeat (20) step();
      #3;
      rst_n = 1'b0;
      busy_from = NEVER; valid_from = NEVER; idle_from = NEVER;
      res_delay = 0; res_width = 0; res_cnt = 0; res_tmo = 0;
      prv_delay = 0; prv_width = 0; prv_cnt = 0; prv_tmo = 0;
      #1;
      chk("t5_async_busy", busy, 0);
      chk("t5_async_delay", delay, 0);
      chk("t5_async_width", width, 0);
      chk("t5_async_pcnt", pcnt, 0);
      trig = 1'b0;
      step(); step();
      rst_n = 1'b1;
      repeat (3) step();
    end
    run_meas(25, 4, 1, 1, 0);
    chk("t5_rearm_delay", delay, 25);
    chk("t5_rearm_width", width, 4);

`ifdef GLITCH_PULSE_MON_BURST_EN
    // T6 burst of four pulses
    run_meas(12, 5, 4, 0, 0);
    chk("t6_pcnt", pcnt, 4);
    chk("t6_width", width, 5);
    chk("t6_delay", delay, 12);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
